// File: rtl/mcu_el2_pkg.sv
// rtl/mcu_el2_pkg.sv - shared PMP types, mode encodings and permission helper
package mcu_el2_pkg;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    EXEC  = 2'd2
  } mcu_el2_pmp_type_e;

  localparam logic [1:0] PMP_OFF   = 2'd0;
  localparam logic [1:0] PMP_TOR   = 2'd1;
  localparam logic [1:0] PMP_NA4   = 2'd2;
  localparam logic [1:0] PMP_NAPOT = 2'd3;

  typedef struct packed {
    logic       lock;
    logic [1:0] mode;
    logic       execute;
    logic       write;
    logic       read;
  } mcu_el2_pmp_cfg_pkt_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } mcu_el2_pmp_chk_state_e;

  // Unlocked entries never restrict machine mode.
  function automatic logic pmp_perm(mcu_el2_pmp_cfg_pkt_t cfg, mcu_el2_pmp_type_e t, logic mmode);
    logic allow;
    if (mmode && !cfg.lock) begin
      allow = 1'b1;
    end else begin
      case (t)
        READ:    allow = cfg.read;
        WRITE:   allow = cfg.write;
        EXEC:    allow = cfg.execute;
        default: allow = 1'b0;
      endcase
    end
    return allow;
  endfunction

endpackage

// File: rtl/mcu_el2_pmp_entry_match.sv
// rtl/mcu_el2_pmp_entry_match.sv - combinational address match for one PMP entry
module mcu_el2_pmp_entry_match
  import mcu_el2_pkg::*;
(
  input  mcu_el2_pmp_cfg_pkt_t cfg,
  input  logic [31:0]          addr,
  input  logic [31:0]          prev_addr,
  input  logic [29:0]          wa,
  output logic                 hit
);

  logic [29:0] a;
  logic [29:0] lo;
  logic [29:0] care;
  logic        unused_bits;

  assign unused_bits = ^{cfg.lock, cfg.execute, cfg.write, cfg.read, addr[31:30], prev_addr[31:30]};

  always_comb begin
    a  = addr[29:0];
    lo = prev_addr[29:0];
    // a ^ (a+1) sets the trailing ones plus the first zero: the NAPOT don't-care span.
    care = ~(a ^ (a + 30'd1));
    case (cfg.mode)
      PMP_TOR:   hit = (lo < a) && (wa >= lo) && (wa < a);
      PMP_NA4:   hit = (wa == a);
      PMP_NAPOT: hit = (((wa ^ a) & care) == 30'd0);
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/mcu_el2_pmp_seq_chk.sv
// rtl/mcu_el2_pmp_seq_chk.sv - sequential PMP checker, ENTRIES_PER_CYCLE entries per scan cycle
// Optional last-hit cache enabled by defining MCU_PMP_HIT_CACHE_EN.
module mcu_el2_pmp_seq_chk
  import mcu_el2_pkg::*;
#(
  parameter int PMP_ENTRIES       = 16,
  parameter int ENTRIES_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  mcu_el2_pmp_cfg_pkt_t pmp_pmpcfg  [PMP_ENTRIES],
  input  logic [31:0]          pmp_pmpaddr [PMP_ENTRIES],
  input  logic                 pmp_cfg_wr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  mcu_el2_pmp_type_e    req_type,
  input  logic                 req_mmode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_allow,
  output logic                 rsp_hit,
  output logic [5:0]           rsp_entry
);

  localparam int EPC = ENTRIES_PER_CYCLE;
  localparam int IW  = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1;
  localparam logic [IW-1:0] LAST_PTR = IW'(PMP_ENTRIES - EPC);

  mcu_el2_pmp_chk_state_e state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [29:0]       wa_q, wa_d;
  mcu_el2_pmp_type_e type_q, type_d;
  logic              mmode_q, mmode_d;
  logic              allow_q, allow_d;
  logic              hit_q, hit_d;
  logic [IW-1:0]     entry_q, entry_d;

  mcu_el2_pmp_cfg_pkt_t g_cfg  [EPC];
  logic [31:0]          g_addr [EPC];
  logic [31:0]          g_prev [EPC];
  logic [IW-1:0]        g_idx  [EPC];
  logic [EPC-1:0]       g_hit;

  logic                 sel_found;
  logic [IW-1:0]        sel_idx;
  mcu_el2_pmp_cfg_pkt_t sel_cfg;

  logic                 c_hit;
  logic [IW-1:0]        c_idx;
  mcu_el2_pmp_cfg_pkt_t c_cfg;
  logic                 unused_req;

  assign unused_req = ^req_addr[1:0];

  always_comb begin
    for (int g = 0; g < EPC; g++) begin
      g_idx[g]  = ptr_q + IW'(g);
      g_cfg[g]  = pmp_pmpcfg[g_idx[g]];
      g_addr[g] = pmp_pmpaddr[g_idx[g]];
      g_prev[g] = (g_idx[g] == '0) ? 32'd0 : pmp_pmpaddr[g_idx[g] - IW'(1)];
    end
  end

  for (genvar g = 0; g < EPC; g++) begin : g_match
    mcu_el2_pmp_entry_match u_match (
      .cfg       (g_cfg[g]),
      .addr      (g_addr[g]),
      .prev_addr (g_prev[g]),
      .wa        (wa_q),
      .hit       (g_hit[g])
    );
  end

  // Walk downwards so the lowest matching index in the group is left selected.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    sel_cfg   = g_cfg[0];
    for (int g = EPC - 1; g >= 0; g--) begin
      if (g_hit[g]) begin
        sel_found = 1'b1;
        sel_idx   = g_idx[g];
        sel_cfg   = g_cfg[g];
      end
    end
  end

`ifdef MCU_PMP_HIT_CACHE_EN
  logic          cv_q, cv_d;
  logic [IW-1:0] ci_q, ci_d;
  logic [31:0]   c_prev;
  logic          c_match;
  logic          lower_off;

  assign c_idx  = ci_q;
  assign c_cfg  = pmp_pmpcfg[ci_q];
  assign c_prev = (ci_q == '0) ? 32'd0 : pmp_pmpaddr[ci_q - IW'(1)];
  assign c_hit  = cv_q & c_match & ~pmp_cfg_wr;

  mcu_el2_pmp_entry_match u_cmatch (
    .cfg       (c_cfg),
    .addr      (pmp_pmpaddr[ci_q]),
    .prev_addr (c_prev),
    .wa        (req_addr[31:2]),
    .hit       (c_match)
  );

  // A cached hit is only equivalent to a full scan if nothing below it could match.
  always_comb begin
    lower_off = 1'b1;
    for (int j = 0; j < PMP_ENTRIES; j++) begin
      if ((IW'(j) < sel_idx) && (pmp_pmpcfg[j].mode != PMP_OFF)) lower_off = 1'b0;
    end
  end

  always_comb begin
    cv_d = cv_q;
    ci_d = ci_q;
    if (pmp_cfg_wr) begin
      cv_d = 1'b0;
    end else if ((state_q == S_SCAN) && sel_found && lower_off) begin
      cv_d = 1'b1;
      ci_d = sel_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cv_q <= 1'b0;
      ci_q <= '0;
    end else begin
      cv_q <= cv_d;
      ci_q <= ci_d;
    end
  end
`else
  assign c_hit = 1'b0;
  assign c_idx = '0;
  assign c_cfg = '0;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      wa_q    <= '0;
      type_q  <= READ;
      mmode_q <= 1'b0;
      allow_q <= 1'b0;
      hit_q   <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wa_q    <= wa_d;
      type_q  <= type_d;
      mmode_q <= mmode_d;
      allow_q <= allow_d;
      hit_q   <= hit_d;
      entry_q <= entry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = c_hit ? S_RESP : S_SCAN;
      S_SCAN: if (!pmp_cfg_wr && (sel_found || (ptr_q == LAST_PTR))) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

  always_comb begin
    ptr_d   = ptr_q;
    wa_d    = wa_q;
    type_d  = type_q;
    mmode_d = mmode_q;
    allow_d = allow_q;
    hit_d   = hit_q;
    entry_d = entry_q;
    if ((state_q == S_IDLE) && req_valid) begin
      wa_d    = req_addr[31:2];
      type_d  = req_type;
      mmode_d = req_mmode;
      ptr_d   = '0;
      if (c_hit) begin
        hit_d   = 1'b1;
        entry_d = c_idx;
        allow_d = pmp_perm(c_cfg, req_type, req_mmode);
      end
    end else if (state_q == S_SCAN) begin
      // A CSR write invalidates any partial result: rescan from entry 0 with live values.
      if (pmp_cfg_wr) begin
        ptr_d = '0;
      end else if (sel_found) begin
        hit_d   = 1'b1;
        entry_d = sel_idx;
        allow_d = pmp_perm(sel_cfg, type_q, mmode_q);
      end else if (ptr_q == LAST_PTR) begin
        hit_d   = 1'b0;
        entry_d = '0;
        allow_d = mmode_q;
      end else begin
        ptr_d = ptr_q + IW'(EPC);
      end
    end
  end

  assign rsp_allow = allow_q;
  assign rsp_hit   = hit_q;
  assign rsp_entry = 6'(entry_q);

endmodule

// File: tb/tb_mcu_el2_pmp_seq_chk.sv
// tb/tb_mcu_el2_pmp_seq_chk.sv - scoreboard bench for the sequential PMP checker
module tb_mcu_el2_pmp_seq_chk;
  import mcu_el2_pkg::*;

  localparam int N = 16;
  localparam int EPC = 4;

  logic                 clk = 1'b0;
  logic                 rst_l = 1'b0;
  mcu_el2_pmp_cfg_pkt_t pmp_pmpcfg  [N];
  logic [31:0]          pmp_pmpaddr [N];
  logic                 pmp_cfg_wr = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [31:0]          req_addr = 32'd0;
  mcu_el2_pmp_type_e    req_type = READ;
  logic                 req_mmode = 1'b0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic                 rsp_allow;
  logic                 rsp_hit;
  logic [5:0]           rsp_entry;

  mcu_el2_pmp_seq_chk #(.PMP_ENTRIES(N), .ENTRIES_PER_CYCLE(EPC)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .pmp_pmpcfg  (pmp_pmpcfg),
    .pmp_pmpaddr (pmp_pmpaddr),
    .pmp_cfg_wr  (pmp_cfg_wr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_type    (req_type),
    .req_mmode   (req_mmode),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_allow   (rsp_allow),
    .rsp_hit     (rsp_hit),
    .rsp_entry   (rsp_entry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       allow;
    logic       hit;
    logic [5:0] entry;
    int         lat;
    string      name;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  bit    seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: latency on first sight of rsp_valid, payload on handshake.
  always @(negedge clk) begin
    if (rst_l && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got allow=%0d hit=%0d entry=%0d with no request pending", rsp_allow, rsp_hit, rsp_entry);
      end else begin
        if (!seen) begin
          chk({exp_q[0].name, "_lat"}, cyc - acc_cyc, exp_q[0].lat);
          seen = 1'b1;
        end
        if (rsp_ready) begin
          chk({exp_q[0].name, "_allow"}, rsp_allow, exp_q[0].allow);
          chk({exp_q[0].name, "_hit"}, rsp_hit, exp_q[0].hit);
          chk({exp_q[0].name, "_entry"}, rsp_entry, exp_q[0].entry);
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic set_ent(int i, logic lock, logic [1:0] mode, logic x, logic w, logic r, logic [31:0] a);
    pmp_pmpcfg[i]  = '{lock, mode, x, w, r};
    pmp_pmpaddr[i] = a;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) set_ent(i, 1'b0, PMP_OFF, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic issue(logic [31:0] addr, mcu_el2_pmp_type_e t, logic m);
    req_addr  = addr;
    req_type  = t;
    req_mmode = m;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no response in %0d cycles, required one", nm, n);
      exp_q.delete();
      seen = 1'b0;
    end
  endtask

  task automatic send(logic [31:0] addr, mcu_el2_pmp_type_e t, logic m,
                      logic ea, logic eh, logic [5:0] ee, int el, string nm);
    exp_t e;
    e.allow = ea; e.hit = eh; e.entry = ee; e.lat = el; e.name = nm;
    exp_q.push_back(e);
    issue(addr, t, m);
    wait_done(nm);
  endtask

  initial begin
    clear_cfg();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_allow", rsp_allow, 0);
    chk("rst_hit", rsp_hit, 0);
    chk("rst_entry", rsp_entry, 0);
    rst_l = 1'b1;
    @(posedge clk);
    #1;

    // NAPOT 8KB at 0, read-only
    set_ent(0, 1'b0, PMP_NAPOT, 1'b0, 1'b0, 1'b1, 32'h0000_03FF);
    send(32'h1004, READ, 1'b0, 1, 1, 0, 1, "napot_u_rd");
    send(32'h1FFC, READ, 1'b0, 1, 1, 0, 1, "napot_top");
    send(32'h2000, READ, 1'b0, 0, 0, 0, 4, "napot_out");
    send(32'h1004, WRITE, 1'b0, 0, 1, 0, 1, "napot_u_wr");
    send(32'h1004, WRITE, 1'b1, 1, 1, 0, 1, "napot_m_wr");
    set_ent(0, 1'b1, PMP_NAPOT, 1'b0, 1'b0, 1'b1, 32'h0000_03FF);
    send(32'h1004, WRITE, 1'b1, 0, 1, 0, 1, "napot_m_wr_lk");
    send(32'h1004, READ, 1'b1, 1, 1, 0, 1, "napot_m_rd_lk");

    // all entries off
    clear_cfg();
    send(32'h8000_0000, READ, 1'b0, 0, 0, 0, 4, "off_u");
    send(32'h8000_0000, READ, 1'b1, 1, 0, 0, 4, "off_m");

    // TOR [0x1000, 0x2000) on entry 5, execute only
    set_ent(4, 1'b0, PMP_OFF, 1'b0, 1'b0, 1'b0, 32'h400);
    set_ent(5, 1'b0, PMP_TOR, 1'b1, 1'b0, 1'b0, 32'h800);
    send(32'h1FFC, EXEC, 1'b0, 1, 1, 5, 2, "tor_x_top");
    send(32'h1000, EXEC, 1'b0, 1, 1, 5, 2, "tor_x_lo");
    send(32'h2000, EXEC, 1'b0, 0, 0, 0, 4, "tor_x_out");
    send(32'h1FFC, READ, 1'b0, 0, 1, 5, 2, "tor_rd");
    set_ent(4, 1'b0, PMP_OFF, 1'b0, 1'b0, 1'b0, 32'h900);
    send(32'h1FFC, EXEC, 1'b0, 0, 0, 0, 4, "tor_empty");

    // lowest index in a group wins; all-ones NAPOT matches everything
    clear_cfg();
    set_ent(8, 1'b0, PMP_NA4, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
    set_ent(9, 1'b0, PMP_NAPOT, 1'b0, 1'b0, 1'b1, 32'h3FFF_FFFF);
    send(32'h100, WRITE, 1'b0, 1, 1, 8, 3, "prio_lo");
    send(32'h104, WRITE, 1'b0, 0, 1, 9, 3, "napot_all");

    // response held with rsp_ready low
    clear_cfg();
    set_ent(0, 1'b0, PMP_NAPOT, 1'b0, 1'b0, 1'b1, 32'h0000_03FF);
    rsp_ready = 1'b0;
    begin
      exp_t e;
      e.allow = 1'b1; e.hit = 1'b1; e.entry = 6'd0; e.lat = 1; e.name = "stall";
      exp_q.push_back(e);
    end
    issue(32'h1004, READ, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_allow", rsp_allow, 1);
      chk("stall_hit", rsp_hit, 1);
      chk("stall_req_ready", req_ready, 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_done("stall");

    // CSR write in the second scan cycle restarts the scan
    clear_cfg();
    set_ent(6, 1'b0, PMP_NA4, 1'b0, 1'b0, 1'b1, 32'h1234);
    begin
      exp_t e;
      e.allow = 1'b1; e.hit = 1'b1; e.entry = 6'd9; e.lat = 5; e.name = "restart";
      exp_q.push_back(e);
    end
    issue(32'h48D0, READ, 1'b0);
    @(posedge clk);
    #1;
    set_ent(6, 1'b0, PMP_OFF, 1'b0, 1'b0, 1'b0, 32'h0);
    set_ent(9, 1'b0, PMP_NA4, 1'b0, 1'b0, 1'b1, 32'h1234);
    pmp_cfg_wr = 1'b1;
    @(posedge clk);
    #1;
    pmp_cfg_wr = 1'b0;
    wait_done("restart");

    // asynchronous reset in the middle of a scan
    clear_cfg();
    issue(32'h100, READ, 1'b1);
    @(posedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_allow", rsp_allow, 0);
    chk("mid_rst_hit", rsp_hit, 0);
    chk("mid_rst_entry", rsp_entry, 0);
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    send(32'h100, READ, 1'b1, 1, 0, 0, 4, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
